fb_pixel_writer: RTL and testbench
==================================

// Module: fb_pixel_writer
// PURPOSE
//  Consumer end of the line drawer's pixel stream: accepts {x,y,color} pixels over rts/rtr,
//  clips against the visible frame, converts to linear framebuffer address y*H_RES+x and
//  issues single-cycle writes to framebuffer memory under a mem_we/mem_rtr handshake.
//  Sits between the line engine's output FIFO and the framebuffer RAM arbiter.
// PARAMETERS
//  H_RES      640  visible pixels per line; x >= H_RES is clipped
//  V_RES      480  visible lines; y >= V_RES is clipped
//  ADDR_W      19  framebuffer address width; must hold H_RES*V_RES-1
//  COLOR_W     12  pixel colour width (4:4:4 RGB)
// PORTS
//  clk        in   1        system clock
//  rst_       in   1        asynchronous active-low reset
//  in_x       in   10       pixel x coordinate
//  in_y       in   10       pixel y coordinate
//  in_color   in   COLOR_W  pixel colour
//  in_rts     in   1        upstream has a valid pixel
//  in_rtr     out  1        block accepts pixel this cycle (transfer = in_rts & in_rtr)
//  mem_addr   out  ADDR_W   framebuffer write address
//  mem_wdata  out  COLOR_W  framebuffer write data
//  mem_we     out  1        write request valid (write occurs when mem_we & mem_rtr)
//  mem_rtr    in   1        memory accepts write this cycle
//  clr_stats  in   1        synchronous clear of both statistics counters
//  busy       out  1        any pixel held in the pipeline
//  pix_written out 16       count of completed memory writes, wraps at 2^16
//  pix_clipped out 16       count of pixels dropped by clipping, wraps at 2^16
// BEHAVIOUR
//  - Reset (rst_=0, async): all stage valids, mem_we, busy, counters = 0; mem_addr/mem_wdata = 0;
//    in_rtr forced 0 while rst_ low, 1 on first cycle after release. Pixels in flight are discarded.
//  - Two-stage pipeline, throughput 1 pixel/clk with mem_rtr held high.
//    S1 (capture): registers x,y,color and clip flag = (x>=H_RES)|(y>=V_RES).
//    S2 (issue): registers address y*H_RES+x (ADDR_W bits, no truncation within frame) and colour;
//    mem_we = s2_valid. Accepted at edge N -> mem_we high during cycle N+2 (no stall).
//  - s1_adv = s1_valid & (s1_clip | ~s2_valid | mem_fire); mem_fire = s2_valid & mem_rtr.
//    in_rtr = ~s1_valid | s1_adv (combinational, no bubble on sustained flow).
//  - Clipped pixel: leaves S1 without entering S2, pix_clipped += 1 that edge; never visible on mem bus.
//  - Stall: while mem_we & ~mem_rtr, mem_addr/mem_wdata/mem_we hold stable; S1 holds; in_rtr=0 once S1 full.
//  - mem_fire and new S2 load in the same cycle: allowed (back-to-back writes).
//  - clr_stats coinciding with an increment event: clear wins, counter = 0.
//  - Boundary: x=H_RES-1,y=V_RES-1 -> addr = H_RES*V_RES-1 (307199 default); x=H_RES -> clipped.
//  - busy = s1_valid | s2_valid.
//  - Pixel order on mem bus equals acceptance order (clipped removed).
// STRUCTURE
//  - Shared package gfx_pkg: H_RES, V_RES, FB_ADDR_W, COLOR_W, COORD_W=10 constants.
//  - One sub-module fb_addr_calc: combinational y*H_RES+x; for H_RES=640 implemented as
//    (y<<9)+(y<<7)+x, generic multiply otherwise. Rest (pipeline regs, handshakes, counters) inline.
// TESTING
//  1 Single pixel (3,2,c=12'habc), mem_rtr=1 -> mem_we one cycle at N+2, addr=1283, wdata=abc, written=1.
//  2 Stream 8 pixels back-to-back, mem_rtr=1 -> in_rtr never drops, 8 consecutive writes, order kept.
//  3 mem_rtr=0 for 5 cycles mid-stream -> mem_addr/wdata stable, in_rtr low after S1 fills, no loss/dup.
//  4 Pixels (640,0),(0,480),(639,479) -> first two clipped (pix_clipped=2), one write addr=307199.
//  5 Assert rst_ low with S1,S2 full -> mem_we,busy,counters 0 immediately; post-reset pixel (0,0) -> addr 0.
//  6 clr_stats pulse same cycle as mem_fire -> pix_written reads 0 next cycle.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics constants for the line-drawing datapath and framebuffer writer.
package gfx_pkg;

  localparam int unsigned H_RES     = 640;
  localparam int unsigned V_RES     = 480;
  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned COLOR_W   = 12;
  localparam int unsigned COORD_W   = 10;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational linear framebuffer address: y * HRes + x.
module fb_addr_calc #(
  parameter int unsigned HRes   = 640,
  parameter int unsigned CoordW = 10,
  parameter int unsigned AddrW  = 19
) (
  input  logic [CoordW-1:0] x_i,
  input  logic [CoordW-1:0] y_i,
  output logic [AddrW-1:0]  addr_o
);

  logic [AddrW-1:0] x_ext;
  logic [AddrW-1:0] y_ext;

  assign x_ext = AddrW'(x_i);
  assign y_ext = AddrW'(y_i);

  if (HRes == 640) begin : g_shift
    // 640 = 512 + 128, so two shifted adds replace the multiplier.
    assign addr_o = (y_ext << 9) + (y_ext << 7) + x_ext;
  end else begin : g_mul
    assign addr_o = y_ext * AddrW'(HRes) + x_ext;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Clips incoming pixels to the visible frame and issues linear-address writes to the
// framebuffer through a two-stage capture/issue pipeline.
module fb_pixel_writer
  import gfx_pkg::*;
#(
  parameter int unsigned HRes   = H_RES,
  parameter int unsigned VRes   = V_RES,
  parameter int unsigned AddrW  = FB_ADDR_W,
  parameter int unsigned ColorW = COLOR_W,
  parameter int unsigned CoordW = COORD_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CoordW-1:0] in_x_i,
  input  logic [CoordW-1:0] in_y_i,
  input  logic [ColorW-1:0] in_color_i,
  input  logic              in_rts_i,
  output logic              in_rtr_o,
  output logic [AddrW-1:0]  mem_addr_o,
  output logic [ColorW-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic              mem_rtr_i,
  input  logic              clr_stats_i,
  output logic              busy_o,
  output logic [15:0]       pix_written_o,
  output logic [15:0]       pix_clipped_o
);

  logic              s1_valid_q, s1_valid_d;
  logic              s1_clip_q, s1_clip_d;
  logic [CoordW-1:0] s1_x_q, s1_x_d;
  logic [CoordW-1:0] s1_y_q, s1_y_d;
  logic [ColorW-1:0] s1_color_q, s1_color_d;

  logic              s2_valid_q, s2_valid_d;
  logic [AddrW-1:0]  s2_addr_q, s2_addr_d;
  logic [ColorW-1:0] s2_color_q, s2_color_d;

  logic [15:0]       written_q, written_d;
  logic [15:0]       clipped_q, clipped_d;

  logic              mem_fire;
  logic              s1_adv;
  logic              in_fire;
  logic              s2_load;
  logic              clip_drop;
  logic [AddrW-1:0]  s1_addr;

  fb_addr_calc #(
    .HRes   (HRes),
    .CoordW (CoordW),
    .AddrW  (AddrW)
  ) u_addr_calc (
    .x_i    (s1_x_q),
    .y_i    (s1_y_q),
    .addr_o (s1_addr)
  );

  assign mem_fire  = s2_valid_q & mem_rtr_i;
  assign s1_adv    = s1_valid_q & (s1_clip_q | ~s2_valid_q | mem_fire);
  assign s2_load   = s1_adv & ~s1_clip_q;
  assign clip_drop = s1_adv & s1_clip_q;
  // Held low for the whole reset assertion so upstream never sees a phantom accept.
  assign in_rtr_o  = rst_ni & (~s1_valid_q | s1_adv);
  assign in_fire   = in_rts_i & in_rtr_o;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_clip_d  = s1_clip_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_color_d = s1_color_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_clip_d  = (32'(in_x_i) >= HRes) | (32'(in_y_i) >= VRes);
      s1_x_d     = in_x_i;
      s1_y_d     = in_y_i;
      s1_color_d = in_color_i;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_addr_d  = s2_addr_q;
    s2_color_d = s2_color_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_addr_d  = s1_addr;
      s2_color_d = s1_color_q;
    end else if (mem_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    written_d = written_q;
    clipped_d = clipped_q;
    if (clr_stats_i) begin
      written_d = '0;
      clipped_d = '0;
    end else begin
      if (mem_fire)  written_d = written_q + 16'd1;
      if (clip_drop) clipped_d = clipped_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_clip_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_color_q <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_color_q <= '0;
      written_q  <= '0;
      clipped_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_clip_q  <= s1_clip_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_color_q <= s1_color_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_color_q <= s2_color_d;
      written_q  <= written_d;
      clipped_q  <= clipped_d;
    end
  end

  assign mem_addr_o    = s2_addr_q;
  assign mem_wdata_o   = s2_color_q;
  assign mem_we_o      = s2_valid_q;
  assign busy_o        = s1_valid_q | s2_valid_q;
  assign pix_written_o = written_q;
  assign pix_clipped_o = clipped_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: vector table plus scoreboard on the memory bus.
module tb_fb_pixel_writer;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] color;
    logic [18:0] addr;
    logic        clip;
  } pix_t;

  logic        clk;
  logic        rst_n;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic [11:0] in_color;
  logic        in_rts;
  logic        in_rtr;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_we;
  logic        mem_rtr;
  logic        clr_stats;
  logic        busy;
  logic [15:0] pix_written;
  logic [15:0] pix_clipped;

  int checks = 0;
  int errors = 0;
  int n_fires = 0;
  int exp_clipped = 0;
  logic [30:0] sb_q[$];
  pix_t vec[20];

  fb_pixel_writer u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_x_i        (in_x),
    .in_y_i        (in_y),
    .in_color_i    (in_color),
    .in_rts_i      (in_rts),
    .in_rtr_o      (in_rtr),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_we_o      (mem_we),
    .mem_rtr_i     (mem_rtr),
    .clr_stats_i   (clr_stats),
    .busy_o        (busy),
    .pix_written_o (pix_written),
    .pix_clipped_o (pix_clipped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor and stall-stability check, sampled on the falling edge.
  initial begin
    logic        prev_stall;
    logic [30:0] prev_bus;
    logic [30:0] exp;
    prev_stall = 1'b0;
    prev_bus   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_we) begin
        if (prev_stall) check("stall_hold", {13'b0, mem_addr, mem_wdata}, {1'b0, prev_bus});
        if (mem_rtr) begin
          prev_stall = 1'b0;
          n_fires++;
          if (sb_q.size() == 0) begin
            check("unexpected_write", {13'b0, mem_addr, mem_wdata}, 32'hffff_ffff);
          end else begin
            exp = sb_q.pop_front();
            check("write_addr", {13'b0, mem_addr}, {13'b0, exp[30:12]});
            check("write_data", {20'b0, mem_wdata}, {20'b0, exp[11:0]});
          end
        end else begin
          prev_stall = 1'b1;
          prev_bus   = {mem_addr, mem_wdata};
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input pix_t p, output int waits);
    in_x     = p.x;
    in_y     = p.y;
    in_color = p.color;
    in_rts   = 1'b1;
    waits    = 0;
    #1;
    while (!in_rtr && waits < 50) begin
      @(posedge clk);
      #2;
      waits++;
    end
    if (waits >= 50) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (p.clip) exp_clipped++;
      else sb_q.push_back({p.addr, p.color});
      @(posedge clk);
      #1;
    end
    in_rts = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_busy", {31'b0, busy}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    int w;
    vec[0]  = '{10'd3,    10'd2,    12'habc, 19'd1283,   1'b0};
    vec[1]  = '{10'd0,    10'd0,    12'h001, 19'd0,      1'b0};
    vec[2]  = '{10'd1,    10'd0,    12'h002, 19'd1,      1'b0};
    vec[3]  = '{10'd639,  10'd0,    12'h003, 19'd639,    1'b0};
    vec[4]  = '{10'd0,    10'd1,    12'h004, 19'd640,    1'b0};
    vec[5]  = '{10'd10,   10'd10,   12'h005, 19'd6410,   1'b0};
    vec[6]  = '{10'd100,  10'd200,  12'h006, 19'd128100, 1'b0};
    vec[7]  = '{10'd320,  10'd240,  12'h007, 19'd153920, 1'b0};
    vec[8]  = '{10'd639,  10'd479,  12'h008, 19'd307199, 1'b0};
    vec[9]  = '{10'd640,  10'd0,    12'h00a, 19'd0,      1'b1};
    vec[10] = '{10'd0,    10'd480,  12'h00b, 19'd0,      1'b1};
    vec[11] = '{10'd639,  10'd479,  12'h00c, 19'd307199, 1'b0};
    vec[12] = '{10'd5,    10'd5,    12'h111, 19'd3205,   1'b0};
    vec[13] = '{10'd6,    10'd5,    12'h222, 19'd3206,   1'b0};
    vec[14] = '{10'd7,    10'd5,    12'h333, 19'd3207,   1'b0};
    vec[15] = '{10'd8,    10'd5,    12'h444, 19'd3208,   1'b0};
    vec[16] = '{10'd9,    10'd5,    12'h555, 19'd3209,   1'b0};
    vec[17] = '{10'd10,   10'd5,    12'h666, 19'd3210,   1'b0};
    vec[18] = '{10'd1023, 10'd1023, 12'h777, 19'd0,      1'b1};
    vec[19] = '{10'd0,    10'd0,    12'hfff, 19'd0,      1'b0};

    rst_n = 1'b0; in_x = '0; in_y = '0; in_color = '0; in_rts = 1'b0;
    mem_rtr = 1'b1; clr_stats = 1'b0;
    #12;
    check("rst_in_rtr", {31'b0, in_rtr}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_addr", {13'b0, mem_addr}, 32'd0);
    check("rst_written", {16'b0, pix_written}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pixel: mem_we pulses exactly in the second cycle after acceptance.
    send(vec[0], w);
    check("t1_we_n1", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check("t1_we_n2", {31'b0, mem_we}, 32'd1);
    @(posedge clk); #1;
    check("t1_we_n3", {31'b0, mem_we}, 32'd0);
    check("t1_written", {16'b0, pix_written}, 32'd1);

    // Back-to-back stream: no accept stalls.
    for (int i = 1; i <= 8; i++) begin
      send(vec[i], w);
      check("t2_no_wait", w, 32'd0);
    end
    drain();
    check("t2_written", {16'b0, pix_written}, 32'(n_fires));

    // Memory stall mid-stream.
    fork
      begin
        for (int i = 12; i <= 17; i++) send(vec[i], w);
      end
      begin
        repeat (2) @(posedge clk);
        #1 mem_rtr = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("t3_rtr_low", {31'b0, in_rtr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 mem_rtr = 1'b1;
      end
    join
    drain();
    check("t3_written", {16'b0, pix_written}, 32'(n_fires));

    // Clipping boundaries.
    for (int i = 9; i <= 11; i++) send(vec[i], w);
    send(vec[18], w);
    drain();
    check("t4_clipped", {16'b0, pix_clipped}, 32'(exp_clipped));
    check("t4_written", {16'b0, pix_written}, 32'(n_fires));

    // Reset with both stages full.
    mem_rtr = 1'b0;
    send(vec[1], w);
    send(vec[2], w);
    check("t5_busy_pre", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    sb_q.delete();
    n_fires = 0;
    exp_clipped = 0;
    #1;
    check("t5_we", {31'b0, mem_we}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_in_rtr", {31'b0, in_rtr}, 32'd0);
    check("t5_written", {16'b0, pix_written}, 32'd0);
    check("t5_clipped", {16'b0, pix_clipped}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rtr = 1'b1;
    #1 check("t5_in_rtr_rel", {31'b0, in_rtr}, 32'd1);
    @(posedge clk); #1;
    send(vec[19], w);
    drain();
    check("t5_written_post", {16'b0, pix_written}, 32'd1);

    // Clear coinciding with a write.
    send(vec[3], w);
    @(posedge clk); #1;
    check("t6_we", {31'b0, mem_we}, 32'd1);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    n_fires = 0;
    check("t6_written", {16'b0, pix_written}, 32'd0);
    check("t6_clipped", {16'b0, pix_clipped}, 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
